spi_target: RTL and testbench
=============================

Name: spi_target

Overview:
- SPI target (slave) endpoint: the responding end of the external SPI bus, which the on-chip masters (AXI Quad SPI or the custom master) drive.
- Oversamples SCK/SS/MOSI in the system clock domain.
- Deserialises MOSI into words and serialises a host-supplied word onto MISO.
- MISO is presented as an _o/_t pair, ready to drive an IOBUF in the top-level pin wrapper.

Parameters:
- DATA_W, 8: bits per SPI word, MSB first.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
- SYNC_STAGES, 2: flip-flop depth of the input synchronisers (minimum 2).
- DEFAULT_TX, {DATA_W{1'b1}}: word sent when no TX data is queued.

Ports:
- clk  input  1  system clock; must be at least 8x SCK frequency.
- rst  input  1  synchronous, active-high reset.
- sck_i  input  1  external SCK, asynchronous.
- ss_i  input  1  external slave select, active-low, asynchronous.
- mosi_i  input  1  external MOSI, asynchronous.
- miso_o  output  1  MISO output data.
- miso_t  output  1  MISO tristate enable; 1 = high-Z.
- rx_data  output  DATA_W  last complete received word.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- tx_data  input  DATA_W  word to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  TX holding register is empty.
- tx_underrun  output  1  one-cycle pulse when DEFAULT_TX is loaded because the holding register was empty.
- busy  output  1  synchronised SS is asserted.

Behaviour:
- **Synchronisers:** sck_i, ss_i and mosi_i each pass through SYNC_STAGES flip-flops, then one history flop for edge detection. Leading/trailing SCK edges are defined relative to CPOL. SCK edges are ignored while synchronised SS is high.
- **Reset values:** miso_o=0, miso_t=1, rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0, busy=0. Bit counter = 0, holding register empty, FSM in IDLE.
- **TX holding register:**
  - A write is accepted when tx_valid && tx_ready; tx_ready drops the next cycle.
  - The holding register is emptied (tx_ready=1 the next cycle) when its content is loaded into the shifter.
  - A load uses only the registered holding content. A write accepted in the same cycle as a load goes to the next word.
- **FSM:**
  - IDLE: miso_t=1, busy=0. On synchronised SS falling, go to ACTIVE, set busy=1 and miso_t=0, and clear the bit counter.
    - If CPHA=0: load the shifter in the same cycle and drive the MSB on miso_o.
  - ACTIVE, sample edge: shift the synchronised MOSI into rx_shift LSB and increment the bit counter.
    - When the counter reaches DATA_W: rx_data <= assembled word, rx_valid=1 for exactly one cycle (the cycle after edge detection), counter wraps to 0.
  - ACTIVE, shift edge:
    - CPHA=0: shift tx left and drive the next bit. The shift edge following the DATA_W-th sample reloads the shifter instead of shifting (start of next word).
    - CPHA=1: the shift edge with counter==0 loads the shifter and drives the MSB; other shift edges shift.
  - Every load: use the holding register if full; otherwise use DEFAULT_TX and pulse tx_underrun for one cycle.
  - ACTIVE, synchronised SS rising: return to IDLE, set miso_t=1 and busy=0. A partial word is discarded (no rx_valid), the counter is cleared, and a queued holding word is retained.
- **Timing:** latency from pin edge to action is SYNC_STAGES+1 clk cycles. Back-to-back words with SS held low are supported with no gap.
- **Reset mid-transfer:** all state returns to its reset values immediately. SCK activity continues to be ignored until a fresh SS falling edge is seen after reset is released.

Decomposition:
- **Shared package spi_pkg:** SPI mode encodings (MODE0..MODE3 as {CPOL,CPHA}), DATA_W default, FSM state typedef (IDLE, ACTIVE).
- **Sub-module sync_edge_det:** SYNC_STAGES synchroniser plus rise/fall pulse outputs. Instantiated for SCK, SS and MOSI (edge outputs unused for MOSI).

Test Plan:
- **Mode 0, one word:** tx_data=8'hA5 queued; master sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C with a single rx_valid pulse; tx_ready returns to 1 after the load.
- **Back-to-back:** queue 8'h11, then 8'h22 during byte 0; master sends 8'hC3, 8'h5A under one SS -> MISO carries 8'h11 then 8'h22; two rx_valid pulses with the matching values; tx_underrun stays 0.
- **Underrun:** nothing queued; master sends 8'h00 -> MISO carries 8'hFF; tx_underrun pulses once; rx_data=8'h00.
- **Abort:** SS deasserted after 5 SCK cycles -> no rx_valid; miso_t=1. The next full transfer of 8'h96 yields rx_data=8'h96.
- **Reset mid-word:** rst asserted after 3 bits -> all outputs at reset values the next cycle. The following transfer of 8'h7E is received correctly.
- **CPOL=1, CPHA=1 build:** exchange 8'hF0 / 8'h0F -> both directions are correct with MSB first; MISO changes only on the leading (falling) SCK edge.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target endpoint.
//   SPI_DATA_W      default word width
//   spi_mode_e      SPI mode encodings as {CPOL, CPHA}
//   spi_state_e     transfer FSM states
//   samples_on_lead true when MOSI is sampled on the leading SCK edge
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // CPHA=0 modes sample on the leading edge and shift on the trailing edge.
  function automatic logic samples_on_lead(input spi_mode_e mode);
    return (mode == MODE0) || (mode == MODE2);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous pin, followed by one history
// flop so that single-cycle rise/fall pulses can be derived.
//   clk, rst  system clock, synchronous active-high reset
//   d_i       asynchronous input
//   q_o       synchronised level
//   rise_o    one-cycle pulse on a synchronised 0->1 transition
//   fall_o    one-cycle pulse on a synchronised 1->0 transition
// INIT is the value every stage takes in reset; choosing it equal to the
// pin's idle level keeps a spurious edge from appearing after reset.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2,
  parameter bit INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;
  logic                   hist_q;
  logic                   hist_d;

  assign chain_d[0] = d_i;
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
    assign chain_d[gi] = chain_q[gi-1];
  end

  always_comb begin
    hist_d = chain_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= {SYNC_STAGES{INIT}};
      hist_q  <= INIT;
    end else begin
      chain_q <= chain_d;
      hist_q  <= hist_d;
    end
  end

  assign q_o    = chain_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~hist_q;
  assign fall_o = ~q_o & hist_q;

endmodule

// File: rtl/spi_target.sv
// SPI target (slave) endpoint, oversampled in the system clock domain.
//   clk, rst             system clock (>= 8x SCK), synchronous active-high reset
//   sck_i, ss_i, mosi_i  asynchronous SPI pins (ss_i active-low)
//   miso_o, miso_t       MISO data and tristate enable (1 = high-Z) for an IOBUF
//   rx_data, rx_valid    last received word and its one-cycle update strobe
//   tx_data, tx_valid    word offered for transmission
//   tx_ready             TX holding register empty
//   tx_underrun          pulse when DEFAULT_TX had to be loaded
//   busy                 a transfer is in progress (SS asserted)
module spi_target
  import spi_pkg::*;
#(
  parameter int              DATA_W      = SPI_DATA_W,
  parameter bit              CPOL        = 1'b0,
  parameter bit              CPHA        = 1'b0,
  parameter int              SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] DEFAULT_TX = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck_i,
  input  logic              ss_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_t,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              busy
);

  localparam spi_mode_e MODE        = spi_mode_e'({CPOL, CPHA});
  localparam bit        SAMPLE_LEAD = samples_on_lead(MODE);
  localparam int        CNT_W       = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // Synchronised pins
  logic sck_s, sck_rise, sck_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .INIT(CPOL)) u_sck_sync (
    .clk(clk), .rst(rst), .d_i(sck_i),
    .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  // SS resets to the asserted level: if the pin is still low when reset is
  // released, no falling edge is seen until SS goes high and low again.
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_ss_sync (
    .clk(clk), .rst(rst), .d_i(ss_i),
    .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .d_i(mosi_i),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic sck_s_unused;

  assign lead_edge    = CPOL ? sck_fall : sck_rise;
  assign trail_edge   = CPOL ? sck_rise : sck_fall;
  assign sample_edge  = SAMPLE_LEAD ? lead_edge : trail_edge;
  assign shift_edge   = SAMPLE_LEAD ? trail_edge : lead_edge;
  assign sck_s_unused = sck_s;

  // State
  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              underrun_q, underrun_d;

  logic              load;
  logic              accept;

  assign accept = tx_valid && !hold_full_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          // CPHA=0 must present the MSB before the first (sampling) edge.
          load      = !CPHA;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          // Partial word is dropped; the holding register keeps its word.
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else if (!ss_s) begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d  = '0;
              rx_data_d  = {rx_shift_q[DATA_W-2:0], mosi_s};
              rx_valid_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else if (shift_edge) begin
            // A shift edge at count 0 starts a word: for CPHA=0 it follows
            // the last sample of the previous word, for CPHA=1 it is the
            // first edge of the word.
            if (bit_cnt_q == '0) begin
              load = 1'b1;
            end else begin
              tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (hold_full_q) begin
        tx_shift_d = hold_q;
      end else begin
        tx_shift_d = DEFAULT_TX;
        underrun_d = 1'b1;
      end
    end
  end

  // Holding register: a load only ever sees the registered content, so a
  // write accepted alongside an underrun load is kept for the next word.
  always_comb begin
    hold_d      = accept ? tx_data : hold_q;
    hold_full_d = (hold_full_q && !load) || accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
    end
  end

  assign miso_o      = tx_shift_q[DATA_W-1];
  assign miso_t      = (state_q == IDLE);
  assign busy        = (state_q == ACTIVE);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = !hold_full_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: a mode-0 instance and a CPOL=1/CPHA=1
// instance share one bench-driven SPI master; sel picks the active target.
module tb_spi_target;

  localparam int H = 6;  // SCK half period in clk cycles

  logic       clk, rst;
  logic       sck_ph, ss_drv, mosi_drv, sel;
  logic [7:0] tx_data;
  logic       tx_valid;

  logic       miso_o0, miso_t0, rx_valid0, tx_ready0, tx_underrun0, busy0;
  logic [7:0] rx_data0;
  logic       miso_o3, miso_t3, rx_valid3, tx_ready3, tx_underrun3, busy3;
  logic [7:0] rx_data3;

  logic ss0, ss3, sck3, tx_valid0, tx_valid3, miso_cur;
  assign ss0       = sel ? 1'b1 : ss_drv;
  assign ss3       = sel ? ss_drv : 1'b1;
  assign sck3      = ~sck_ph;
  assign tx_valid0 = tx_valid & ~sel;
  assign tx_valid3 = tx_valid & sel;
  assign miso_cur  = sel ? miso_o3 : miso_o0;

  spi_target #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk(clk), .rst(rst), .sck_i(sck_ph), .ss_i(ss0), .mosi_i(mosi_drv),
    .miso_o(miso_o0), .miso_t(miso_t0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .tx_data(tx_data), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .tx_underrun(tx_underrun0), .busy(busy0)
  );

  spi_target #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
    .clk(clk), .rst(rst), .sck_i(sck3), .ss_i(ss3), .mosi_i(mosi_drv),
    .miso_o(miso_o3), .miso_t(miso_t3), .rx_data(rx_data3), .rx_valid(rx_valid3),
    .tx_data(tx_data), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
    .tx_underrun(tx_underrun3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int und_cnt  = 0;
  int rxv_cnt  = 0;
  int bad_miso = 0;
  logic [7:0] rx_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Scoreboard: expected received words are queued by the master and
  // popped here when the target strobes rx_valid.
  always @(negedge clk) begin
    if (tx_underrun0 || tx_underrun3) und_cnt++;
    if (rx_valid0 || rx_valid3) begin
      logic [7:0] got;
      got = rx_valid3 ? rx_data3 : rx_data0;
      rxv_cnt++;
      if (rx_q.size() == 0) begin
        n_checks++;
        $display("FAIL rx_unexpected: got rx_valid with rx_data=%02h, required no rx_valid", got);
      end else begin
        logic [7:0] exp;
        exp = rx_q.pop_front();
        $display("rx word: rx_data=%02h expected=%02h", got, exp);
        chk("rx_data", {24'd0, got}, {24'd0, exp});
      end
    end
  end

  // In the CPHA=1 build MISO may only move after a leading (falling) edge.
  always @(miso_o3) begin
    if (sel && busy3 && !sck_ph) bad_miso++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic queue_tx(input logic [7:0] w);
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic ss_low();
    @(negedge clk);
    ss_drv = 1'b0;
    wait_clk(4);
  endtask

  task automatic ss_high();
    wait_clk(H);
    ss_drv = 1'b0;
    ss_drv = 1'b1;
    wait_clk(H);
  endtask

  task automatic spi_word(input int nbits, input logic [7:0] out, input bit cpha,
                          output logic [7:0] got);
    got = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi_drv = out[i];
        wait_clk(H);
        got[i] = miso_cur;
        sck_ph = 1'b1;
        wait_clk(H);
        sck_ph = 1'b0;
      end else begin
        wait_clk(H);
        sck_ph   = 1'b1;
        mosi_drv = out[i];
        wait_clk(H);
        got[i] = miso_cur;
        sck_ph = 1'b0;
      end
    end
  endtask

  task automatic check_reset0(input string tag);
    chk({tag, "_miso_o"},   {31'd0, miso_o0},   32'd0);
    chk({tag, "_miso_t"},   {31'd0, miso_t0},   32'd1);
    chk({tag, "_rx_data"},  {24'd0, rx_data0},  32'd0);
    chk({tag, "_rx_valid"}, {31'd0, rx_valid0}, 32'd0);
    chk({tag, "_tx_ready"}, {31'd0, tx_ready0}, 32'd1);
    chk({tag, "_underrun"}, {31'd0, tx_underrun0}, 32'd0);
    chk({tag, "_busy"},     {31'd0, busy0},     32'd0);
  endtask

  typedef struct {
    logic [7:0] mosi;
    logic       q_en;
    logic [7:0] txw;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    int         exp_und;
  } vec_t;

  vec_t vecs[3];

  initial begin
    #50_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] got, got2;
    int und0, rxv0;

    vecs[0] = '{mosi: 8'h3C, q_en: 1'b1, txw: 8'hA5, exp_rx: 8'h3C, exp_miso: 8'hA5, exp_und: 0};
    vecs[1] = '{mosi: 8'h00, q_en: 1'b0, txw: 8'h00, exp_rx: 8'h00, exp_miso: 8'hFF, exp_und: 1};
    vecs[2] = '{mosi: 8'hE7, q_en: 1'b1, txw: 8'h18, exp_rx: 8'hE7, exp_miso: 8'h18, exp_und: 0};

    rst = 1'b1; ss_drv = 1'b1; sck_ph = 1'b0; mosi_drv = 1'b0;
    tx_valid = 1'b0; tx_data = '0; sel = 1'b0;
    wait_clk(5);
    check_reset0("reset");
    rst = 1'b0;
    wait_clk(8);

    // Single mode-0 words from the table
    for (int v = 0; v < 3; v++) begin
      und0 = und_cnt;
      rxv0 = rxv_cnt;
      if (vecs[v].q_en) begin
        queue_tx(vecs[v].txw);
        chk("tx_ready_full", {31'd0, tx_ready0}, 32'd0);
      end
      ss_low();
      chk("miso_t_active", {31'd0, miso_t0}, 32'd0);
      chk("busy_active",   {31'd0, busy0},   32'd1);
      rx_q.push_back(vecs[v].exp_rx);
      spi_word(8, vecs[v].mosi, 1'b0, got);
      chk("underrun_word", und_cnt - und0, vecs[v].exp_und);
      ss_high();
      $display("xfer %0d: mosi=%02h miso=%02h expected miso=%02h", v, vecs[v].mosi, got, vecs[v].exp_miso);
      chk("miso_word", {24'd0, got}, {24'd0, vecs[v].exp_miso});
      chk("tx_ready_after", {31'd0, tx_ready0}, 32'd1);
      chk("rx_valid_count", rxv_cnt - rxv0, 32'd1);
      chk("miso_t_idle", {31'd0, miso_t0}, 32'd1);
    end

    // Back-to-back words under one SS, second word queued mid byte 0
    und0 = und_cnt;
    rxv0 = rxv_cnt;
    queue_tx(8'h11);
    ss_low();
    rx_q.push_back(8'hC3);
    rx_q.push_back(8'h5A);
    fork
      spi_word(8, 8'hC3, 1'b0, got);
      begin wait_clk(20); queue_tx(8'h22); end
    join
    spi_word(8, 8'h5A, 1'b0, got2);
    chk("b2b_underrun", und_cnt - und0, 32'd0);
    ss_high();
    $display("xfer b2b: miso=%02h,%02h expected 11,22", got, got2);
    chk("b2b_miso0", {24'd0, got},  32'h11);
    chk("b2b_miso1", {24'd0, got2}, 32'h22);
    chk("b2b_rx_valid_count", rxv_cnt - rxv0, 32'd2);

    // Abort after 5 bits, then a full word
    rxv0 = rxv_cnt;
    ss_low();
    spi_word(5, 8'hAA, 1'b0, got);
    ss_high();
    $display("xfer abort: 5 bits sent");
    chk("abort_rx_valid", rxv_cnt - rxv0, 32'd0);
    chk("abort_miso_t", {31'd0, miso_t0}, 32'd1);
    chk("abort_busy",   {31'd0, busy0},   32'd0);
    ss_low();
    rx_q.push_back(8'h96);
    spi_word(8, 8'h96, 1'b0, got);
    ss_high();
    $display("xfer after abort: miso=%02h expected ff", got);
    chk("abort_next_miso", {24'd0, got}, 32'hFF);

    // Reset in the middle of a word
    ss_low();
    queue_tx(8'h55);
    chk("pre_reset_tx_ready", {31'd0, tx_ready0}, 32'd0);
    spi_word(3, 8'h7E, 1'b0, got);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset0("midreset");
    ss_high();
    ss_low();
    rx_q.push_back(8'h7E);
    spi_word(8, 8'h7E, 1'b0, got);
    ss_high();
    $display("xfer after reset: miso=%02h expected ff", got);
    chk("reset_next_miso", {24'd0, got}, 32'hFF);

    // CPOL=1, CPHA=1 build
    sel = 1'b1;
    wait_clk(4);
    und0 = und_cnt;
    queue_tx(8'hF0);
    ss_low();
    chk("m3_miso_t_active", {31'd0, miso_t3}, 32'd0);
    rx_q.push_back(8'h0F);
    spi_word(8, 8'h0F, 1'b1, got);
    ss_high();
    $display("xfer mode3: mosi=0f miso=%02h expected f0", got);
    chk("m3_miso_word", {24'd0, got}, 32'hF0);
    chk("m3_underrun", und_cnt - und0, 32'd0);
    chk("m3_miso_on_trailing", bad_miso, 32'd0);
    chk("m3_miso_t_idle", {31'd0, miso_t3}, 32'd1);

    wait_clk(20);
    chk("scoreboard_drained", rx_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
